serial_adder_n: RTL

Parametrised bit-serial adder/subtractor built around a single one-bit full-adder cell. It accepts two WIDTH-bit operands on a start pulse and processes one bit per clock, LSB first. It then presents the sum, carry-out and signed overflow with a one-cycle done strobe. It is the multi-bit, clocked successor to the lab's combinational one-bit full adder, and it adds subtract mode.

---
 rtl/serial_adder_pkg.sv | 23 ++
 rtl/fa_cell.sv | 22 ++
 rtl/serial_adder_n.sv | 129 ++++++++++++
 3 files changed

// File: rtl/serial_adder_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : serial_adder_pkg
//  Description : State and mode encodings shared by the bit-serial adder.
//  Revision    : 1.0 - initial release
// ============================================================================
package serial_adder_pkg;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_RUN  = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  localparam logic MODE_ADD = 1'b0;
  localparam logic MODE_SUB = 1'b1;

  typedef enum logic [1:0] {
    S_IDLE = ST_IDLE,
    S_RUN  = ST_RUN,
    S_DONE = ST_DONE
  } state_e;

endpackage
`default_nettype wire

// File: rtl/fa_cell.sv
`default_nettype none
// ============================================================================
//  Module      : fa_cell
//  Description : One-bit combinational full adder.
//  Revision    : 1.0 - initial release
// ============================================================================
module fa_cell (
  input  logic a_i,
  input  logic b_i,
  input  logic cin_i,
  output logic s_o,
  output logic co_o
);

  // Sum and carry of a single bit position
  always_comb begin
    s_o  = a_i ^ b_i ^ cin_i;
    co_o = (a_i & b_i) | (cin_i & (a_i ^ b_i));
  end

endmodule
`default_nettype wire

// File: rtl/serial_adder_n.sv
`default_nettype none
// ============================================================================
//  Module      : serial_adder_n
//  Description : WIDTH-bit serial adder/subtractor, one bit per clock, LSB
//                first, built around a single full-adder cell.
//  Revision    : 1.0 - initial release
// ============================================================================
module serial_adder_n
  import serial_adder_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start_i,
  input  logic             sub_i,
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  output logic             busy_o,
  output logic             done_o,
  output logic [WIDTH-1:0] sum_o,
  output logic             cout_o,
  output logic             ovf_o
);

  localparam int CW = $clog2(WIDTH + 1);
  localparam logic [CW-1:0] C_LAST = CW'(WIDTH - 1);

  state_e           state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [WIDTH-1:0] sum_q, sum_d;
  logic             carry_q, carry_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             cout_q, cout_d;
  logic             ovf_q, ovf_d;

  logic             w_s;
  logic             w_co;
  logic [WIDTH-1:0] w_sum_shift;

  fa_cell u_fa (
    .a_i   (a_q[0]),
    .b_i   (b_q[0]),
    .cin_i (carry_q),
    .s_o   (w_s),
    .co_o  (w_co)
  );

  // New sum bit enters at the MSB; after WIDTH shifts bit 0 sits at the LSB
  generate
    if (WIDTH == 1) begin : g_w1
      assign w_sum_shift = w_s;
    end else begin : g_wn
      assign w_sum_shift = {w_s, sum_q[WIDTH-1:1]};
    end
  endgenerate

  // Next-state and datapath update
  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    sum_d   = sum_q;
    carry_d = carry_q;
    cnt_d   = cnt_q;
    cout_d  = cout_q;
    ovf_d   = ovf_q;
    case (state_q)
      S_IDLE, S_DONE: begin
        if (start_i) begin
          // Subtraction is a + ~b + 1: invert b and seed the carry with 1
          a_d     = a_i;
          b_d     = (sub_i == MODE_SUB) ? ~b_i : b_i;
          carry_d = sub_i;
          cnt_d   = '0;
          state_d = S_RUN;
        end else if (state_q == S_DONE) begin
          state_d = S_IDLE;
        end
      end
      S_RUN: begin
        a_d     = a_q >> 1;
        b_d     = b_q >> 1;
        sum_d   = w_sum_shift;
        carry_d = w_co;
        cnt_d   = cnt_q + CW'(1);
        if (cnt_q == C_LAST) begin
          // On the MSB cycle carry_q is the carry into the MSB
          cout_d  = w_co;
          ovf_d   = carry_q ^ w_co;
          state_d = S_DONE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // State and datapath registers with synchronous reset
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      a_q     <= '0;
      b_q     <= '0;
      sum_q   <= '0;
      carry_q <= 1'b0;
      cnt_q   <= '0;
      cout_q  <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      sum_q   <= sum_d;
      carry_q <= carry_d;
      cnt_q   <= cnt_d;
      cout_q  <= cout_d;
      ovf_q   <= ovf_d;
    end
  end

  assign busy_o = (state_q == S_RUN);
  assign done_o = (state_q == S_DONE);
  assign sum_o  = sum_q;
  assign cout_o = cout_q;
  assign ovf_o  = ovf_q;

endmodule
`default_nettype wire
